// File: rtl/mlp_frame_loader_if.sv
`default_nettype none
// ============================================================================
// mlp_frame_loader_if : feature-beat stream and result handshake bundle
// Rev 1.0
// ============================================================================
interface mlp_frame_loader_if #(
    parameter int WIDTH_A  = 4,
    parameter int OUTWIDTH = 2
);
    logic                feat_valid;
    logic                feat_ready;
    logic [WIDTH_A-1:0]  feat_data;
    logic                feat_last;
    logic                res_valid;
    logic                res_ready;
    logic [OUTWIDTH-1:0] res_class;
    logic                res_err;

    // Loader side
    modport slave (
        input  feat_valid, feat_data, feat_last, res_ready,
        output feat_ready, res_valid, res_class, res_err
    );

    // Sample source / result sink side
    modport master (
        output feat_valid, feat_data, feat_last, res_ready,
        input  feat_ready, res_valid, res_class, res_err
    );
endinterface
`default_nettype wire

// File: rtl/mlp_frame_loader.sv
`default_nettype none
// ============================================================================
// mlp_frame_loader : packs NUM_A feature beats into the classifier bus,
// waits SETTLE cycles, captures the class and returns it on a handshake.
// Rev 1.0
// ============================================================================
module mlp_frame_loader #(
    parameter int NUM_A    = 10,
    parameter int WIDTH_A  = 4,
    parameter int OUTWIDTH = 2,
    parameter int SETTLE   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mlp_frame_loader_if.slave          bus,
    output logic [NUM_A*WIDTH_A-1:0]   inp_o,
    input  logic [OUTWIDTH-1:0]        out_i,
    output logic                       busy_o
);
    localparam int IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_A - 1);
    localparam logic [7:0]       c_CNT_INIT = 8'(SETTLE - 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [OUTWIDTH-1:0] cls_q, cls_d;
    logic                err_q, err_d;
    logic                rv_q, rv_d;
    logic [WIDTH_A-1:0]  slot_q [NUM_A];

    logic w_ready;
    logic w_accept;
    logic w_last_idx;
    logic w_handshake;

    assign w_ready     = (state_q == S_LOAD);
    assign w_accept    = bus.feat_valid && w_ready;
    assign w_last_idx  = (idx_q == c_LAST_IDX);
    assign w_handshake = rv_q && bus.res_ready;

    assign bus.feat_ready = w_ready;
    assign bus.res_valid  = rv_q;
    assign bus.res_class  = cls_q;
    assign bus.res_err    = err_q;
    assign busy_o         = (state_q == S_WAIT) || (state_q == S_RESP);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        err_d   = err_q;
        rv_d    = rv_q;
        case (state_q)
            S_LOAD: begin
                if (w_accept) begin
                    // Beat count defines the frame; feat_last is only cross-checked.
                    if (bus.feat_last != w_last_idx) err_d = 1'b1;
                    if (w_last_idx) begin
                        state_d = S_WAIT;
                        cnt_d   = c_CNT_INIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    cls_d   = out_i;
                    rv_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (w_handshake) begin
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            cls_q   <= '0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
        end
    end

    // Slots are never cleared between frames; each is rewritten before the next WAIT.
    for (genvar g = 0; g < NUM_A; g++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q[g] <= '0;
            end else if (w_accept && (idx_q == IDX_W'(g))) begin
                slot_q[g] <= bus.feat_data;
            end
        end
        assign inp_o[g*WIDTH_A +: WIDTH_A] = slot_q[g];
    end
endmodule
`default_nettype wire

// File: tb/tb_mlp_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_mlp_frame_loader : randomized frames, reference model + result scoreboard
// Rev 1.0
// ============================================================================
module tb_mlp_frame_loader;
    localparam int NUM_A    = 10;
    localparam int WIDTH_A  = 4;
    localparam int OUTWIDTH = 2;
    localparam int SETTLE   = 2;
    localparam int PERIOD   = NUM_A + SETTLE + 1;
    localparam logic [NUM_A-1:0] c_LAST_OK = NUM_A'(1) << (NUM_A - 1);

    typedef struct {
        logic [OUTWIDTH-1:0]      cls;
        logic                     err;
        longint                   cyc;
        logic [NUM_A*WIDTH_A-1:0] inp;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_A*WIDTH_A-1:0] inp;
    logic [OUTWIDTH-1:0]      out;
    logic                     busy;
    int                       top_mode = 1;
    int                       checks = 0;
    int                       errors = 0;
    longint                   cyc = 0;

    exp_t   exp_q[$];
    exp_t   cur;
    exp_t   e;
    int     beats[$];
    logic   frame_err = 1'b0;
    logic   seen = 1'b0;
    longint res_cyc[$];
    int     acc;

    mlp_frame_loader_if #(.WIDTH_A(WIDTH_A), .OUTWIDTH(OUTWIDTH)) bus ();

    mlp_frame_loader #(
        .NUM_A(NUM_A), .WIDTH_A(WIDTH_A), .OUTWIDTH(OUTWIDTH), .SETTLE(SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .inp_o (inp),
        .out_i (out),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the combinational classifier top
    function automatic logic [OUTWIDTH-1:0] classify(input logic [NUM_A*WIDTH_A-1:0] v, input int mode);
        int s;
        s = 0;
        if (mode == 0) return OUTWIDTH'(int'(v[WIDTH_A-1:0]) % 4);
        for (int i = 0; i < NUM_A; i++) s += (i + 1) * int'(v[i*WIDTH_A +: WIDTH_A]);
        return OUTWIDTH'(s % 4);
    endfunction
    always_comb out = classify(inp, top_mode);

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model (accepted beats -> expected results) and result monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            beats.delete();
            exp_q.delete();
            frame_err = 1'b0;
            seen = 1'b0;
        end else begin
            if (bus.feat_valid && bus.feat_ready) begin
                if (bus.feat_last != (beats.size() == NUM_A - 1)) frame_err = 1'b1;
                beats.push_back(int'(bus.feat_data));
                if (beats.size() == NUM_A) begin
                    acc = 0;
                    e.inp = '0;
                    for (int i = 0; i < NUM_A; i++) begin
                        acc += (i + 1) * beats[i];
                        e.inp[i*WIDTH_A +: WIDTH_A] = WIDTH_A'(beats[i]);
                    end
                    if (top_mode == 0) acc = beats[0];
                    e.cls = OUTWIDTH'(acc % 4);
                    e.err = frame_err;
                    e.cyc = cyc + 1 + SETTLE;
                    exp_q.push_back(e);
                    beats.delete();
                    frame_err = 1'b0;
                end
            end

            check("ready_vs_busy", longint'(bus.feat_ready), longint'(!busy));
            if (bus.res_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got class %0d with no frame pending (t=%0t)",
                                 bus.res_class, $time);
                    end else begin
                        cur = exp_q.pop_front();
                        check("res_class", longint'(bus.res_class), longint'(cur.cls));
                        check("res_err", longint'(bus.res_err), longint'(cur.err));
                        check("res_latency", cyc, cur.cyc);
                        check("inp_packing", longint'(inp), longint'(cur.inp));
                        res_cyc.push_back(cyc);
                    end
                end else begin
                    check("class_hold", longint'(bus.res_class), longint'(cur.cls));
                    check("err_hold", longint'(bus.res_err), longint'(cur.err));
                end
                seen = !bus.res_ready;
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic send_beat(input logic [WIDTH_A-1:0] d, input logic l, input int pct);
        int guard;
        while ($urandom_range(99) >= pct) begin
            @(posedge clk);
            #1;
        end
        bus.feat_valid = 1'b1;
        bus.feat_data  = d;
        bus.feat_last  = l;
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus.feat_ready) break;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: got feat_ready 0 for %0d cycles expected 1", guard);
                bus.feat_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.feat_valid = 1'b0;
        bus.feat_data  = WIDTH_A'($urandom);
        bus.feat_last  = 1'($urandom);
    endtask

    task automatic send_frame(input logic [NUM_A*WIDTH_A-1:0] f, input logic [NUM_A-1:0] lasts, input int pct);
        for (int i = 0; i < NUM_A; i++) send_beat(f[i*WIDTH_A +: WIDTH_A], lasts[i], pct);
    endtask

    function automatic logic [NUM_A*WIDTH_A-1:0] rand_feats();
        logic [NUM_A*WIDTH_A-1:0] v;
        for (int i = 0; i < NUM_A; i++) v[i*WIDTH_A +: WIDTH_A] = WIDTH_A'($urandom);
        return v;
    endfunction

    task automatic wait_valid(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.res_valid) begin
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL %s: got res_valid 0 after %0d cycles expected 1", name, guard);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || bus.res_valid || beats.size() != 0) begin
            guard++;
            if (guard > 500) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: got %0d results pending expected 0", exp_q.size());
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_A-1:0] lasts;
        int n0;

        bus.feat_valid = 1'b0;
        bus.feat_data  = '0;
        bus.feat_last  = 1'b0;
        bus.res_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inp", longint'(inp), 0);
        check("rst_feat_ready", longint'(bus.feat_ready), 1);
        check("rst_res_valid", longint'(bus.res_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_res_class", longint'(bus.res_class), 0);
        check("rst_res_err", longint'(bus.res_err), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: reset mid-LOAD after four beats
        for (int i = 0; i < 4; i++) send_beat(WIDTH_A'($urandom_range(1, 15)), 1'b0, 100);
        #2 rst_n = 1'b0;
        #1;
        check("t1_inp_cleared", longint'(inp), 0);
        check("t1_feat_ready", longint'(bus.feat_ready), 1);
        check("t1_busy", longint'(busy), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(rand_feats(), c_LAST_OK, 100);
        wait_idle();

        // T2: features 0..9, class = slot0 % 4
        top_mode = 0;
        send_frame(40'h9876543210, c_LAST_OK, 100);
        wait_valid("t2_result");
        check("t2_inp", longint'(inp), longint'(40'h9876543210));
        check("t2_class", longint'(bus.res_class), 0);
        check("t2_err", longint'(bus.res_err), 0);
        wait_idle();
        top_mode = 1;

        // T3: 50% valid, sink stalls 20 cycles while the next frame is offered
        bus.res_ready = 1'b0;
        send_frame(rand_feats(), c_LAST_OK, 50);
        fork
            send_frame(rand_feats(), c_LAST_OK, 50);
            begin
                wait_valid("t3_result");
                repeat (20) begin
                    check("t3_no_ready_in_resp", longint'(bus.feat_ready), 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 bus.res_ready = 1'b1;
            end
        join
        wait_idle();

        // T4: feat_last on beat 5 only, then a clean frame
        send_frame(rand_feats(), NUM_A'(1) << 5, 100);
        wait_valid("t4_err_result");
        check("t4_err_set", longint'(bus.res_err), 1);
        wait_idle();
        send_frame(rand_feats(), c_LAST_OK, 100);
        wait_valid("t4_clean_result");
        check("t4_err_clear", longint'(bus.res_err), 0);
        wait_idle();

        // T5: 100 back-to-back frames, occasional framing faults
        n0 = res_cyc.size();
        for (int f = 0; f < 100; f++) begin
            lasts = c_LAST_OK;
            if ($urandom_range(7) == 0) lasts[$urandom_range(NUM_A - 1)] ^= 1'b1;
            send_frame(rand_feats(), lasts, 100);
        end
        wait_idle();
        check("t5_result_count", longint'(res_cyc.size() - n0), 100);
        for (int k = n0 + 1; k < res_cyc.size(); k++)
            check("t5_period", res_cyc[k] - res_cyc[k-1], PERIOD);

        // T6: reset while a result is pending
        bus.res_ready = 1'b0;
        send_frame(rand_feats(), c_LAST_OK, 100);
        wait_valid("t6_result");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_valid_async_drop", longint'(bus.res_valid), 0);
        check("t6_busy", longint'(busy), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t6_no_result", longint'(bus.res_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        checks++;
        errors++;
        $display("FAIL watchdog: got run still active at %0t expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
